// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video reads take priority, CPU reads are serialised behind
// a small posted-write FIFO so that a read always observes every earlier CPU write.
module vram_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 12,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              wr_lock,
  output logic              fifo_empty,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] fa_q [WFIFO_DEPTH];
  logic [DATA_W-1:0] fd_q [WFIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_q, rvalid_q, vid_valid_q;

  logic empty, full, vid_gnt, rd_gnt, dr_gnt, cpu_take, push, pop;

  // A pending read overrides wr_lock so the FIFO it waits on can actually drain.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(WFIFO_DEPTH));
    vid_gnt  = vid_req & ~rst;
    rd_gnt   = ~rst & ~vid_req & (state_q == RD_WAIT) & empty;
    dr_gnt   = ~rst & ~vid_req & ~empty & (~wr_lock | (state_q == RD_WAIT));
    cpu_take = (state_q == IDLE) & ~ack_q & cpu_req;
    push     = cpu_take & cpu_we & ~full;
    pop      = dr_gnt;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    ram_en    = vid_gnt | rd_gnt | dr_gnt;
    ram_we    = dr_gnt;
    ram_wdata = fd_q[rptr_q];
    if (vid_gnt)     ram_addr = vid_addr;
    else if (rd_gnt) ram_addr = rd_addr_q;
    else             ram_addr = fa_q[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wptr_q] <= cpu_addr;
      fd_q[wptr_q] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      vid_valid_q <= 1'b0;
    end else begin
      ack_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      vid_valid_q <= vid_gnt;
      unique case (state_q)
        IDLE: begin
          if (cpu_take && !cpu_we) begin
            rd_addr_q <= cpu_addr;
            state_q   <= RD_WAIT;
          end else if (push) begin
            ack_q <= 1'b1;
          end
        end
        RD_WAIT: if (rd_gnt) state_q <= RD_DATA;
        RD_DATA: begin
          rdata_q  <= ram_rdata;
          ack_q    <= 1'b1;
          rvalid_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vid_valid  = vid_valid_q;
  assign vid_data   = ram_rdata;
  assign cpu_ack    = ack_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign fifo_empty = empty;

endmodule
